// File: rtl/aes_pkg.sv
// Shared AES byte/state types and ShiftRows index maps.
// State bytes are column-major: index = row + 4*column.
package aes_pkg;

    localparam int unsigned NB          = 4;
    localparam int unsigned STATE_BYTES = 16;

    typedef logic [7:0]                  byte_t;
    typedef byte_t [STATE_BYTES-1:0]     state_t;
    typedef byte_t [NB-1:0]              word_t;

    // Source byte index for ShiftRows: row kept, column advanced by row (2-bit wrap = mod 4).
    function automatic logic [3:0] fwd_src(input logic [3:0] idx);
        logic [1:0] row;
        logic [1:0] col;
        row = idx[1:0];
        col = idx[3:2];
        return {2'(col + row), row};
    endfunction

    // Source byte index for InvShiftRows: column retreated by row.
    function automatic logic [3:0] inv_src(input logic [3:0] idx);
        logic [1:0] row;
        logic [1:0] col;
        row = idx[1:0];
        col = idx[3:2];
        return {2'(col - row), row};
    endfunction

endpackage

// File: rtl/shift_row_stage_rot_word.sv
// RotWord for the key schedule: combinational one-byte left rotate of a 4-byte word.
module rot_word
    import aes_pkg::*;
(
    input  word_t word_i,
    output word_t word_o
);

    always_comb begin
        word_o = '0;
        for (int unsigned j = 0; j < NB; j++) begin
            word_o[j] = word_i[(j + 1) % NB];
        end
    end

endmodule

// File: rtl/shift_row_stage.sv
// Registered AES ShiftRows stage plus RotWord of the last round-key word.
// Optional INV_SHIFT_EN adds an inv port selecting InvShiftRows.
module shift_row_stage
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
`ifdef INV_SHIFT_EN
    input  logic       inv,
`endif
    input  logic       in_valid,
    input  logic [7:0] G0, G1, G2, G3, G4, G5, G6, G7,
    input  logic [7:0] G8, G9, GA, GB, GC, GD, GE, GF,
    input  logic [7:0] KC, KD, KE, KF,
    output logic       out_valid,
    output logic [7:0] R0, R1, R2, R3, R4, R5, R6, R7,
    output logic [7:0] R8, R9, RA, RB, RC, RD, RE, RF,
    output logic [7:0] KAC, KAD, KAE, KAF
);

    state_t g_s;
    state_t sel_s;
    word_t  key_w;
    word_t  key_rot;

    state_t r_q, r_d;
    word_t  ka_q, ka_d;
    logic   out_valid_q, out_valid_d;

    assign g_s   = {GF, GE, GD, GC, GB, GA, G9, G8, G7, G6, G5, G4, G3, G2, G1, G0};
    assign key_w = {KF, KE, KD, KC};

    rot_word u_rot_word (
        .word_i (key_w),
        .word_o (key_rot)
    );

    always_comb begin
        logic [3:0] src;
        src   = '0;
        sel_s = '0;
        for (int unsigned i = 0; i < STATE_BYTES; i++) begin
            src = fwd_src(4'(i));
`ifdef INV_SHIFT_EN
            if (inv) begin
                src = inv_src(4'(i));
            end
`endif
            sel_s[i] = g_s[src];
        end
    end

    always_comb begin
        r_d         = r_q;
        ka_d        = ka_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            r_d  = sel_s;
            ka_d = key_rot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q         <= '0;
            ka_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            r_q         <= r_d;
            ka_q        <= ka_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign R0  = r_q[0];
    assign R1  = r_q[1];
    assign R2  = r_q[2];
    assign R3  = r_q[3];
    assign R4  = r_q[4];
    assign R5  = r_q[5];
    assign R6  = r_q[6];
    assign R7  = r_q[7];
    assign R8  = r_q[8];
    assign R9  = r_q[9];
    assign RA  = r_q[10];
    assign RB  = r_q[11];
    assign RC  = r_q[12];
    assign RD  = r_q[13];
    assign RE  = r_q[14];
    assign RF  = r_q[15];
    assign KAC = ka_q[0];
    assign KAD = ka_q[1];
    assign KAE = ka_q[2];
    assign KAF = ka_q[3];

endmodule

// File: tb/tb_shift_row_stage.sv
// Self-checking bench for shift_row_stage: directed vector table plus random stimulus vs. a reference model.
module tb_shift_row_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         inv_in = 1'b0;
    logic [127:0] g_in = '0;
    logic [31:0]  k_in = '0;

    logic       out_valid;
    logic [7:0] R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, RA, RB, RC, RD, RE, RF;
    logic [7:0] KAC, KAD, KAE, KAF;
    logic [127:0] r_out;
    logic [31:0]  ka_out;

    assign r_out  = {RF, RE, RD, RC, RB, RA, R9, R8, R7, R6, R5, R4, R3, R2, R1, R0};
    assign ka_out = {KAF, KAE, KAD, KAC};

    shift_row_stage dut (
        .clk       (clk),
        .rst       (rst),
`ifdef INV_SHIFT_EN
        .inv       (inv_in),
`endif
        .in_valid  (in_valid),
        .G0 (g_in[7:0]),     .G1 (g_in[15:8]),    .G2 (g_in[23:16]),   .G3 (g_in[31:24]),
        .G4 (g_in[39:32]),   .G5 (g_in[47:40]),   .G6 (g_in[55:48]),   .G7 (g_in[63:56]),
        .G8 (g_in[71:64]),   .G9 (g_in[79:72]),   .GA (g_in[87:80]),   .GB (g_in[95:88]),
        .GC (g_in[103:96]),  .GD (g_in[111:104]), .GE (g_in[119:112]), .GF (g_in[127:120]),
        .KC (k_in[7:0]),     .KD (k_in[15:8]),    .KE (k_in[23:16]),   .KF (k_in[31:24]),
        .out_valid (out_valid),
        .R0 (R0), .R1 (R1), .R2 (R2), .R3 (R3), .R4 (R4), .R5 (R5), .R6 (R6), .R7 (R7),
        .R8 (R8), .R9 (R9), .RA (RA), .RB (RB), .RC (RC), .RD (RD), .RE (RE), .RF (RF),
        .KAC (KAC), .KAD (KAD), .KAE (KAE), .KAF (KAF)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model state (what the output registers should hold).
    logic [127:0] m_r;
    logic [31:0]  m_ka;
    logic         m_v;

    function automatic logic [127:0] shift_ref(input logic [127:0] g, input bit inverse);
        logic [127:0] res;
        int src_col;
        res = '0;
        for (int row = 0; row < 4; row++) begin
            for (int col = 0; col < 4; col++) begin
                src_col = inverse ? (col - row + 4) % 4 : (col + row) % 4;
                res[8*(row + 4*col) +: 8] = g[8*(row + 4*src_col) +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [31:0] rot_ref(input logic [31:0] k);
        logic [31:0] res;
        res = '0;
        for (int j = 0; j < 4; j++) res[8*j +: 8] = k[8*((j + 1) % 4) +: 8];
        return res;
    endfunction

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, and advance the reference model.
    task automatic step(input logic r, input logic v, input logic iv,
                        input logic [127:0] g, input logic [31:0] k);
        rst = r; in_valid = v; inv_in = iv; g_in = g; k_in = k;
        @(posedge clk);
        #1;
        if (r) begin
            m_r = '0; m_ka = '0; m_v = 1'b0;
        end else begin
            m_v = v;
            if (v) begin
`ifdef INV_SHIFT_EN
                m_r = shift_ref(g, iv);
`else
                m_r = shift_ref(g, 1'b0);
`endif
                m_ka = rot_ref(k);
            end
        end
    endtask

    typedef struct {
        string        name;
        logic         rst;
        logic         v;
        logic         inv;
        logic [127:0] g;
        logic [31:0]  k;
        logic [127:0] er;
        logic [31:0]  eka;
        logic         ev;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic r, input logic v, input logic iv,
                                input logic [127:0] g, input logic [31:0] k,
                                input logic [127:0] er, input logic [31:0] eka, input logic ev);
        vec_t x;
        x.name = name; x.rst = r; x.v = v; x.inv = iv; x.g = g; x.k = k;
        x.er = er; x.eka = eka; x.ev = ev;
        return x;
    endfunction

    localparam logic [127:0] G_ID  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] G_11  = {16{8'h11}};
    localparam logic [127:0] G_33  = {16{8'h33}};
    localparam logic [127:0] G_AA  = {16{8'hAA}};

    initial begin
        logic [127:0] g_rand;
        logic [31:0]  k_rand;
        logic         r_rand, v_rand, i_rand;

        vecs.push_back(mk("reset_priority", 1, 1, 0, G_11, 32'h11111111, '0, '0, 0));
        vecs.push_back(mk("fwd_identity", 0, 1, 0, G_ID, 32'h0F0E0D0C,
                          128'h0B06010C_07020D08_030E0904_0F0A0500, 32'h0C0F0E0D, 1));
        vecs.push_back(mk("stream_1x", 0, 1, 0, 128'h1F1E1D1C_1B1A1918_17161514_13121110, 32'h1F1E1D1C,
                          128'h1B16111C_17121D18_131E1914_1F1A1510, 32'h1C1F1E1D, 1));
        vecs.push_back(mk("stream_5x", 0, 1, 0, 128'h5F5E5D5C_5B5A5958_57565554_53525150, 32'h5F5E5D5C,
                          128'h5B56515C_57525D58_535E5954_5F5A5550, 32'h5C5F5E5D, 1));
        vecs.push_back(mk("stream_7x", 0, 1, 0, 128'h7F7E7D7C_7B7A7978_77767574_73727170, 32'h7F7E7D7C,
                          128'h7B76717C_77727D78_737E7974_7F7A7570, 32'h7C7F7E7D, 1));
        vecs.push_back(mk("hold_no_valid", 0, 0, 0, G_AA, 32'hAAAAAAAA,
                          128'h7B76717C_77727D78_737E7974_7F7A7570, 32'h7C7F7E7D, 0));
        vecs.push_back(mk("midstream_reset", 1, 1, 0, G_33, 32'h33333333, '0, '0, 0));
        vecs.push_back(mk("equal_bytes", 0, 1, 0, G_33, 32'h33333333, G_33, 32'h33333333, 1));
`ifdef INV_SHIFT_EN
        vecs.push_back(mk("inv_identity", 0, 1, 1, G_ID, 32'h0F0E0D0C,
                          128'h0306090C_0F020508_0B0E0104_070A0D00, 32'h0C0F0E0D, 1));
        vecs.push_back(mk("inv_then_fwd", 0, 1, 0, G_ID, 32'h0F0E0D0C,
                          128'h0B06010C_07020D08_030E0904_0F0A0500, 32'h0C0F0E0D, 1));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].v, vecs[i].inv, vecs[i].g, vecs[i].k);
            check128({vecs[i].name, "_R"}, r_out, vecs[i].er);
            check32({vecs[i].name, "_KA"}, ka_out, vecs[i].eka);
            check32({vecs[i].name, "_valid"}, {31'b0, out_valid}, {31'b0, vecs[i].ev});
        end

        // Random traffic with occasional resets and idle cycles.
        for (int n = 0; n < 100; n++) begin
            g_rand = {$urandom, $urandom, $urandom, $urandom};
            k_rand = $urandom;
            r_rand = ($urandom_range(15) == 0);
            v_rand = ($urandom_range(3) != 0);
            i_rand = $urandom_range(1);
            step(r_rand, v_rand, i_rand, g_rand, k_rand);
            check128("rand_R", r_out, m_r);
            check32("rand_KA", ka_out, m_ka);
            check32("rand_valid", {31'b0, out_valid}, {31'b0, m_v});
        end

`ifdef INV_SHIFT_EN
        // Round trip: forward-shifted state fed back with inv=1 must reproduce the original.
        for (int n = 0; n < 100; n++) begin
            g_rand = {$urandom, $urandom, $urandom, $urandom};
            k_rand = $urandom;
            step(0, 1, 1, shift_ref(g_rand, 1'b0), k_rand);
            check128("roundtrip_R", r_out, g_rand);
            check32("roundtrip_KA", ka_out, rot_ref(k_rand));
        end
`endif

        // Reset after a valid result clears everything.
        step(0, 1, 0, G_ID, 32'h0F0E0D0C);
        step(1, 0, 0, G_AA, 32'hAAAAAAAA);
        check128("final_reset_R", r_out, '0);
        check32("final_reset_KA", ka_out, '0);
        check32("final_reset_valid", {31'b0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
